io_input_debounce: RTL and testbench

//  Conditions the two raw 4-bit switch ports before the I/O input register stage reads them.

---
 rtl/io_input_debounce_pkg.sv | 26 ++
 rtl/io_input_debounce_bit.sv | 56 +++++
 rtl/io_input_debounce.sv | 64 ++++++
 tb/tb_io_input_debounce.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_input_debounce_pkg.sv
// Shared defaults and helpers for the switch-input debounce block.
// The port width is shared with the I/O input register stage.
package io_input_debounce_pkg;

   localparam int IO_PORT_WIDTH = 4;
   localparam int IO_DB_CYCLES  = 50000;
   localparam int IO_CNT_W      = 16;

   typedef enum logic [1:0] {
      DB_EQUAL    = 2'd0,
      DB_COUNTING = 2'd1,
      DB_ACCEPT   = 2'd2
   } db_action_e;

   // Decides what a bit does this cycle from its synchronised input, its
   // settled value, and whether the stability count has reached its end.
   function automatic db_action_e db_action(input logic s2, input logic st, input logic at_last);
      db_action_e act;
      act = DB_EQUAL;
      if (s2 != st) begin
         act = at_last ? DB_ACCEPT : DB_COUNTING;
      end
      return act;
   endfunction

endpackage

// File: rtl/io_input_debounce_bit.sv
// One switch bit: 2-FF synchroniser followed by a stability counter that
// accepts a new level only after DB_CYCLES consecutive mismatching cycles.
module debounce_bit
   import io_input_debounce_pkg::*;
#(
   parameter int DB_CYCLES = IO_DB_CYCLES,
   parameter int CNT_W     = IO_CNT_W
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw,
   output logic stable,
   output logic upd
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             st_q;
   logic             upd_q;
   logic [CNT_W-1:0] cnt_q;
   db_action_e       act_d;

   assign act_d = db_action(s2_q, st_q, (cnt_q == CNT_LAST));

   // Any cycle where the input agrees with the settled level restarts the
   // count, so the counter can never run past CNT_LAST.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         st_q  <= 1'b0;
         upd_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw;
         s2_q  <= s1_q;
         upd_q <= 1'b0;
         case (act_d)
            DB_EQUAL:    cnt_q <= '0;
            DB_COUNTING: cnt_q <= cnt_q + CNT_W'(1);
            DB_ACCEPT: begin
               st_q  <= s2_q;
               cnt_q <= '0;
               upd_q <= 1'b1;
            end
            default:     cnt_q <= '0;
         endcase
      end
   end

   assign stable = st_q;
   assign upd    = upd_q;

endmodule

// File: rtl/io_input_debounce.sv
// Debounces two switch banks bit by bit and reports settled changes with a
// one-cycle pulse plus a sticky flag the CPU clears.
module io_input_debounce
   import io_input_debounce_pkg::*;
#(
   parameter int WIDTH     = IO_PORT_WIDTH,
   parameter int DB_CYCLES = IO_DB_CYCLES,
   parameter int CNT_W     = IO_CNT_W
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] raw_port0,
   input  logic [WIDTH-1:0] raw_port1,
   input  logic             clr_changed,
   output logic [WIDTH-1:0] in_port0,
   output logic [WIDTH-1:0] in_port1,
   output logic             change_pulse,
   output logic             changed
);

   logic [2*WIDTH-1:0] raw_all;
   logic [2*WIDTH-1:0] st_all;
   logic [2*WIDTH-1:0] upd_all;
   logic               change_pulse_q;
   logic               changed_q;

   assign raw_all = {raw_port1, raw_port0};

   generate
      for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_bit
         debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
         ) u_bit (
            .clock  (clock),
            .resetn (resetn),
            .raw    (raw_all[gi]),
            .stable (st_all[gi]),
            .upd    (upd_all[gi])
         );
      end
   endgenerate

   // A new pulse takes priority over a clear so no change can be lost.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         change_pulse_q <= 1'b0;
         changed_q      <= 1'b0;
      end else begin
         change_pulse_q <= |upd_all;
         if (change_pulse_q) begin
            changed_q <= 1'b1;
         end else if (clr_changed) begin
            changed_q <= 1'b0;
         end
      end
   end

   assign in_port0     = st_all[WIDTH-1:0];
   assign in_port1     = st_all[2*WIDTH-1:WIDTH];
   assign change_pulse = change_pulse_q;
   assign changed      = changed_q;

endmodule

// File: tb/tb_io_input_debounce.sv
// Scoreboard bench for io_input_debounce with a window-based reference model
// (a bit settles once its synchronised samples all differ from the settled level).
module tb_io_input_debounce;

   localparam int W     = 4;
   localparam int DB    = 4;
   localparam int CW    = 3;
   localparam int NB    = 2*W;
   localparam int HLEN  = DB + 2;

   logic         clock = 1'b0;
   logic         resetn = 1'b0;
   logic [W-1:0] raw_port0 = '0;
   logic [W-1:0] raw_port1 = '0;
   logic         clr_changed = 1'b0;
   logic [W-1:0] in_port0;
   logic [W-1:0] in_port1;
   logic         change_pulse;
   logic         changed;

   io_input_debounce #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .raw_port0    (raw_port0),
      .raw_port1    (raw_port1),
      .clr_changed  (clr_changed),
      .in_port0     (in_port0),
      .in_port1     (in_port1),
      .change_pulse (change_pulse),
      .changed      (changed)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] in0;
      logic [W-1:0] in1;
      logic         pulse;
      logic         chg;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 0;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[b][0] is the oldest sample; the last two entries are still in the synchroniser.
   logic         hist [NB][HLEN];
   logic [NB-1:0] m_st;
   logic         m_settled_prev;
   logic         m_pulse;
   logic         m_changed;

   task automatic model_clear();
      for (int b = 0; b < NB; b++)
         for (int j = 0; j < HLEN; j++) hist[b][j] = 1'b0;
      m_st = '0;
      m_settled_prev = 1'b0;
      m_pulse = 1'b0;
      m_changed = 1'b0;
   endtask

   task automatic model_push();
      exp_t e;
      e.in0   = m_st[W-1:0];
      e.in1   = m_st[NB-1:W];
      e.pulse = m_pulse;
      e.chg   = m_changed;
      sb_q.push_back(e);
      started = 1;
   endtask

   task automatic model_edge();
      logic [NB-1:0] raw_all;
      logic          any_settle;
      logic          all_diff;
      logic          new_changed;
      raw_all = {raw_port1, raw_port0};
      any_settle = 1'b0;
      for (int b = 0; b < NB; b++) begin
         for (int j = 0; j < HLEN-1; j++) hist[b][j] = hist[b][j+1];
         hist[b][HLEN-1] = raw_all[b];
         all_diff = 1'b1;
         for (int j = 0; j < DB; j++)
            if (hist[b][j] == m_st[b]) all_diff = 1'b0;
         if (all_diff) begin
            m_st[b] = ~m_st[b];
            any_settle = 1'b1;
         end
      end
      new_changed = m_pulse ? 1'b1 : (clr_changed ? 1'b0 : m_changed);
      m_pulse = m_settled_prev;
      m_settled_prev = any_settle;
      m_changed = new_changed;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clock or negedge resetn);
         if (!resetn) begin
            model_clear();
            sb_q.delete();
         end else begin
            model_edge();
         end
         model_push();
      end
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb_q.size() == 0) begin
            if (started) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
            end
         end else begin
            e = sb_q.pop_front();
            chk("in_port0", in_port0, e.in0);
            chk("in_port1", in_port1, e.in1);
            chk("change_pulse", {3'b0, change_pulse}, {3'b0, e.pulse});
            chk("changed", {3'b0, changed}, {3'b0, e.chg});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in0"}, in_port0, 4'h0);
      chk({tag, "_in1"}, in_port1, 4'h0);
      chk({tag, "_pulse"}, {3'b0, change_pulse}, 4'h0);
      chk({tag, "_changed"}, {3'b0, changed}, 4'h0);
   endtask

   initial begin
      int idx;
      // Reset held with bank 0 driven high
      raw_port0 = 4'hF;
      step(3);
      chk_all_zero("reset");
      resetn = 1'b1;
      step(10);

      // Short glitch on bank 1 bit 2
      raw_port1[2] = 1'b1;
      step(3);
      raw_port1[2] = 1'b0;
      step(10);

      // Bounce on bank 0 bit 0, then settle high
      raw_port0[0] = 1'b0;
      step(10);
      for (int i = 0; i < 10; i++) begin
         raw_port0[0] = ~raw_port0[0];
         step(1);
      end
      raw_port0[0] = 1'b1;
      step(10);

      // Simultaneous change on both banks
      raw_port0 = 4'hA;
      raw_port1 = 4'h5;
      step(10);

      // Sticky flag: clear alone, then clear coinciding with a pulse
      clr_changed = 1'b1;
      step(1);
      clr_changed = 1'b0;
      step(1);
      raw_port1 = 4'h0;
      step(7);
      clr_changed = 1'b1;
      step(2);
      clr_changed = 1'b0;
      step(4);

      // Asynchronous reset pulse in the middle of a count
      raw_port0 = 4'h6;
      step(4);
      #1;
      resetn = 1'b0;
      #1;
      chk_all_zero("async_rst");
      resetn = 1'b1;
      step(12);

      // Randomised switch activity and clears
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, NB-1);
            if (idx < W) raw_port0[idx] = ~raw_port0[idx];
            else         raw_port1[idx-W] = ~raw_port1[idx-W];
         end
         clr_changed = ($urandom_range(0, 5) == 0);
         step(1);
      end
      clr_changed = 1'b0;
      step(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
